crc16_framer: RTL



---
 rtl/crc16_framer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/crc16_framer.sv
// CRC-16 (poly 0x8005, MSB-first, unreflected) framer: forwards payload bytes unchanged
// and appends the CRC high byte then the low byte, flagging the low byte as end-of-frame.
module crc16_framer #(
    parameter logic [15:0] CRC_INIT   = 16'h0000,
    parameter logic [15:0] CRC_XOROUT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [15:0] crc_last,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        PAYLOAD = 2'd0,
        CRC_HI  = 2'd1,
        CRC_LO  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] crc, crc_nxt;
    logic [15:0] crc_out;
    logic [7:0]  m_data_nxt;
    logic        m_valid_nxt;
    logic        m_last_nxt;
    logic        out_free;
    logic        frame_done;

    // One byte of the serial shift register, unrolled into a flat XOR network.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) begin
                r = r ^ 16'h8005;
            end
        end
        return r;
    endfunction

    assign out_free = !m_valid || m_ready;
    assign crc_out  = crc ^ CRC_XOROUT;
    assign s_ready  = (state == PAYLOAD) && out_free;

    always_comb begin
        state_nxt   = state;
        crc_nxt     = crc;
        m_data_nxt  = m_data;
        m_valid_nxt = m_valid;
        m_last_nxt  = m_last;
        frame_done  = 1'b0;
        if (out_free) begin
            m_valid_nxt = 1'b0;
            unique case (state)
                PAYLOAD: begin
                    if (s_valid) begin
                        m_data_nxt  = s_data;
                        m_valid_nxt = 1'b1;
                        m_last_nxt  = 1'b0;
                        crc_nxt     = crc_step(crc, s_data);
                        if (s_last) begin
                            state_nxt = CRC_HI;
                        end
                    end
                end
                CRC_HI: begin
                    m_data_nxt  = crc_out[15:8];
                    m_valid_nxt = 1'b1;
                    m_last_nxt  = 1'b0;
                    state_nxt   = CRC_LO;
                end
                CRC_LO: begin
                    m_data_nxt  = crc_out[7:0];
                    m_valid_nxt = 1'b1;
                    m_last_nxt  = 1'b1;
                    crc_nxt     = CRC_INIT;
                    frame_done  = 1'b1;
                    state_nxt   = PAYLOAD;
                end
                default: begin
                    state_nxt = PAYLOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PAYLOAD;
            crc     <= CRC_INIT;
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            crc     <= crc_nxt;
            m_data  <= m_data_nxt;
            m_valid <= m_valid_nxt;
            m_last  <= m_last_nxt;
        end
    end

    // Frame statistics move on the edge that loads the CRC low byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_last <= 16'h0000;
        end else if (frame_done) begin
            crc_last <= crc_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= 16'h0000;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
